// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding and the
// width of the per-entry repeat count.
package pulse_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUNNING = 2'd2,
        ST_FINISH  = 2'd3
    } seq_state_t;

    // Width of the REPEAT input and of the pulse counter.
    localparam int REP_W = 8;

endpackage : pulse_seq_pkg

// File: rtl/period_table.sv
// Period table: DEPTH x WIDTH register file, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
// A read in the same cycle as a write to the same address returns the old
// contents, since the write only lands on the clock edge.
module period_table #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : period_table

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays a table of period values into a pulse_generator.
// Each entry is loaded with a one-cycle LOAD strobe and then allowed to run
// for REPEAT generator pulses (rising edges of PULSE_IN) before the next
// entry is loaded. After the last entry a one-cycle DONE strobe is issued.
//
// All outputs are registered. Output registers are computed from the next
// state so that LOAD rises on the same edge that enters LOADING (one cycle
// after START is sampled). DBG_STATE exposes the FSM state register.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic [AW:0]      SEQ_LEN,
    input  logic [REP_W-1:0] REPEAT,
    input  logic             START,
    input  logic             ABORT,
    input  logic             PULSE_IN,
    output logic             LOAD,
    output logic [WIDTH-1:0] LOAD_VALUE,
    output logic             BUSY,
    output logic             DONE,
    output logic [AW-1:0]    CUR_INDEX,
    output seq_state_t       DBG_STATE
);

    localparam logic [AW-1:0]    IDX_ONE = AW'(1);
    localparam logic [REP_W-1:0] CNT_ONE = REP_W'(1);

    seq_state_t       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    len_last_q, len_last_d;   // SEQ_LEN-1, captured on START
    logic [REP_W-1:0] rep_last_q, rep_last_d;   // max(REPEAT,1)-1, captured on START
    logic [REP_W-1:0] cnt_q, cnt_d;             // PULSE_IN edges seen for this entry
    logic             pulse_prev_q;
    logic             pulse_rise;

    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] load_value_q, load_value_d;

    logic [WIDTH-1:0] table_rd_data;

    // The table is addressed with the next index so the value is ready to be
    // registered on the edge that enters LOADING.
    period_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_period_table (
        .clk     (CLK),
        .wr_en   (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (idx_d),
        .rd_data (table_rd_data)
    );

    assign pulse_rise = PULSE_IN & ~pulse_prev_q;

    // State, counters, PULSE_IN history and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_last_q   <= '0;
            rep_last_q   <= '0;
            cnt_q        <= '0;
            pulse_prev_q <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_value_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_last_q   <= len_last_d;
            rep_last_q   <= rep_last_d;
            cnt_q        <= cnt_d;
            pulse_prev_q <= PULSE_IN;
            load_q       <= load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_value_q <= load_value_d;
        end
    end

    // Next-state, index and pulse-count logic; ABORT overrides everything
    // outside IDLE, including a completion edge in the same cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_last_d = len_last_q;
        rep_last_d = rep_last_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (START && (SEQ_LEN != '0)) begin
                    state_d    = ST_LOADING;
                    idx_d      = '0;
                    // SEQ_LEN is 1..DEPTH here, so the low bits minus one
                    // give the last index without needing the top bit.
                    len_last_d = SEQ_LEN[AW-1:0] - IDX_ONE;
                    rep_last_d = (REPEAT == '0) ? '0 : (REPEAT - CNT_ONE);
                end
            end
            ST_LOADING: begin
                // Edges arriving while the generator is being loaded are not counted.
                cnt_d   = '0;
                state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (pulse_rise) begin
                    if (cnt_q == rep_last_q) begin
                        if (idx_q == len_last_q) begin
                            state_d = ST_FINISH;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = ST_LOADING;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ABORT && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
        end
    end

    // Moore outputs, decoded from the next state and registered above.
    always_comb begin
        load_d       = (state_d == ST_LOADING);
        busy_d       = (state_d == ST_LOADING) || (state_d == ST_RUNNING);
        // A zero-length START completes at once without leaving IDLE.
        done_d       = (state_d == ST_FINISH) ||
                       ((state_q == ST_IDLE) && START && (SEQ_LEN == '0));
        load_value_d = (state_d == ST_LOADING) ? table_rd_data : load_value_q;
    end

    assign LOAD       = load_q;
    assign LOAD_VALUE = load_value_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign CUR_INDEX  = idx_q;
    assign DBG_STATE  = state_q;

endmodule : pulse_sequencer
